// File: rtl/range_tracker_pkg.sv
// range_tracker_pkg
// Shared types and helpers for the range_tracker block.
//   state_e    : capture FSM states
//   STATE_W    : state encoding width
//   cnt_width(): sample counter width for a given MAX_SAMPLES
package range_tracker_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // Counter must hold the value MAX_SAMPLES itself.
    function automatic int cnt_width(input int max_samples);
        return $clog2(max_samples + 1);
    endfunction

endpackage

// File: rtl/range_tracker_minmax.sv
// range_tracker_minmax
// Combinational compare unit: folds one sample into the running min/max.
// Optional feature macro: RANGE_TRACKER_SIGNED_EN (signed compare path).
// Ports:
//   min_i, max_i   current extremes
//   sample_i       new sample
//   sel_signed_i   1 = two's-complement compare (macro builds only)
//   min_o, max_o   updated extremes
module range_tracker_minmax #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] min_i,
    input  logic [WIDTH-1:0] max_i,
    input  logic [WIDTH-1:0] sample_i,
    input  logic             sel_signed_i,
    output logic [WIDTH-1:0] min_o,
    output logic [WIDTH-1:0] max_o
);

    logic lt_min;
    logic gt_max;

`ifdef RANGE_TRACKER_SIGNED_EN
    always_comb begin
        if (sel_signed_i) begin
            lt_min = $signed(sample_i) < $signed(min_i);
            gt_max = $signed(sample_i) > $signed(max_i);
        end else begin
            lt_min = sample_i < min_i;
            gt_max = sample_i > max_i;
        end
    end
`else
    logic unused_sel_signed;
    assign unused_sel_signed = sel_signed_i;
    assign lt_min = sample_i < min_i;
    assign gt_max = sample_i > max_i;
`endif

    assign min_o = lt_min ? sample_i : min_i;
    assign max_o = gt_max ? sample_i : max_i;

endmodule

// File: rtl/range_tracker.sv
// range_tracker
// Streaming min/max/range finder with sample-count limit, abort and busy.
// Optional feature macro: RANGE_TRACKER_SIGNED_EN (honours signed_mode).
// Ports:
//   clk, rst_n     clock, async active-low reset
//   data_in        sample, taken each RUN edge while go=1
//   go             capture window
//   abort          synchronous return to IDLE, clears everything
//   signed_mode    two's-complement compare select
//   range          max - min of the last capture
//   min_o, max_o   captured extremes
//   count          samples in the last capture
//   finish         results valid (DONE)
//   error          capture overflowed (ERR)
//   busy           capture in progress (RUN)
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | waiting for go
// RUN   | sampling; running min/max and count update each edge
// DONE  | results held, finish=1; go restarts a capture
// ERR   | overflow, results zeroed; needs go low then high to restart
module range_tracker
    import range_tracker_pkg::*;
#(
    parameter  int WIDTH       = 8,
    parameter  int MAX_SAMPLES = 255,
    localparam int CNT_W       = cnt_width(MAX_SAMPLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             go,
    input  logic             abort,
    input  logic             signed_mode,
    output logic [WIDTH-1:0] range,
    output logic [WIDTH-1:0] min_o,
    output logic [WIDTH-1:0] max_o,
    output logic [CNT_W-1:0] count,
    output logic             finish,
    output logic             error,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] range_q, range_d;
    logic [WIDTH-1:0] min_res_q, min_res_d;
    logic [WIDTH-1:0] max_res_q, max_res_d;
    logic [CNT_W-1:0] cnt_res_q, cnt_res_d;
    logic             go_low_seen_q, go_low_seen_d;

    logic [WIDTH-1:0] nxt_min;
    logic [WIDTH-1:0] nxt_max;
    logic [WIDTH:0]   span_full;
    logic             unused_span_msb;

    range_tracker_minmax #(
        .WIDTH (WIDTH)
    ) u_minmax (
        .min_i        (min_q),
        .max_i        (max_q),
        .sample_i     (data_in),
        .sel_signed_i (signed_mode),
        .min_o        (nxt_min),
        .max_o        (nxt_max)
    );

    // In signed mode max >= min as signed values, so the true span still
    // fits in WIDTH unsigned bits; the extra bit is only the borrow.
    assign span_full       = {1'b0, max_q} - {1'b0, min_q};
    assign unused_span_msb = span_full[WIDTH];

    always_comb begin
        state_d       = state_q;
        min_d         = min_q;
        max_d         = max_q;
        cnt_d         = cnt_q;
        range_d       = range_q;
        min_res_d     = min_res_q;
        max_res_d     = max_res_q;
        cnt_res_d     = cnt_res_q;
        go_low_seen_d = go_low_seen_q;

        if (abort) begin
            state_d       = ST_IDLE;
            min_d         = '0;
            max_d         = '0;
            cnt_d         = '0;
            range_d       = '0;
            min_res_d     = '0;
            max_res_d     = '0;
            cnt_res_d     = '0;
            go_low_seen_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        state_d = ST_RUN;
                        min_d   = data_in;
                        max_d   = data_in;
                        cnt_d   = CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!go) begin
                        state_d   = ST_DONE;
                        range_d   = span_full[WIDTH-1:0];
                        min_res_d = min_q;
                        max_res_d = max_q;
                        cnt_res_d = cnt_q;
                    end else if (cnt_q == CNT_W'(MAX_SAMPLES)) begin
                        state_d       = ST_ERR;
                        range_d       = '0;
                        min_res_d     = '0;
                        max_res_d     = '0;
                        cnt_res_d     = '0;
                        go_low_seen_d = 1'b0;
                    end else begin
                        min_d = nxt_min;
                        max_d = nxt_max;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ERR: begin
                    // go stuck high after an overflow must not restart.
                    if (!go) begin
                        go_low_seen_d = 1'b1;
                    end else if (go_low_seen_q) begin
                        state_d       = ST_RUN;
                        min_d         = data_in;
                        max_d         = data_in;
                        cnt_d         = CNT_W'(1);
                        go_low_seen_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            min_q         <= '0;
            max_q         <= '0;
            cnt_q         <= '0;
            range_q       <= '0;
            min_res_q     <= '0;
            max_res_q     <= '0;
            cnt_res_q     <= '0;
            go_low_seen_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            min_q         <= min_d;
            max_q         <= max_d;
            cnt_q         <= cnt_d;
            range_q       <= range_d;
            min_res_q     <= min_res_d;
            max_res_q     <= max_res_d;
            cnt_res_q     <= cnt_res_d;
            go_low_seen_q <= go_low_seen_d;
        end
    end

    assign range  = range_q;
    assign min_o  = min_res_q;
    assign max_o  = max_res_q;
    assign count  = cnt_res_q;
    assign finish = (state_q == ST_DONE);
    assign error  = (state_q == ST_ERR);
    assign busy   = (state_q == ST_RUN);

endmodule

// File: tb/tb_range_tracker.sv
module tb_range_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       go = 1'b0;
    logic       go4 = 1'b0;
    logic       abort = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] data_in = 8'd0;

    logic [7:0] range, min_o, max_o, count;
    logic       finish, error, busy;
    logic [7:0] range4, min4, max4;
    logic [2:0] count4;
    logic       finish4, error4, busy4;

    range_tracker #(.WIDTH(8), .MAX_SAMPLES(255)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .go(go), .abort(abort),
        .signed_mode(signed_mode), .range(range), .min_o(min_o), .max_o(max_o),
        .count(count), .finish(finish), .error(error), .busy(busy)
    );

    range_tracker #(.WIDTH(8), .MAX_SAMPLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .go(go4), .abort(abort),
        .signed_mode(signed_mode), .range(range4), .min_o(min4), .max_o(max4),
        .count(count4), .finish(finish4), .error(error4), .busy(busy4)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] rng;
        logic [7:0] mn;
        logic [7:0] mx;
        logic [7:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] stim_q[$];
    int         n_vec = 0;
    int         n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_range"},  32'(range),  0);
        chk({tag, "_min"},    32'(min_o),  0);
        chk({tag, "_max"},    32'(max_o),  0);
        chk({tag, "_count"},  32'(count),  0);
        chk({tag, "_finish"}, 32'(finish), 0);
        chk({tag, "_error"},  32'(error),  0);
        chk({tag, "_busy"},   32'(busy),   0);
    endtask

    // Drives stim_q as one capture, pushes the model result, then waits
    // for finish and pops/compares it.
    task automatic run_capture(input string tag, input bit sgn);
        exp_t       e;
        logic [7:0] mn, mx;
        bit         es;
        int         lat;
        es = sgn;
`ifndef RANGE_TRACKER_SIGNED_EN
        es = 1'b0;
`endif
        mn = stim_q[0];
        mx = stim_q[0];
        foreach (stim_q[i]) begin
            if (es) begin
                if ($signed(stim_q[i]) < $signed(mn)) mn = stim_q[i];
                if ($signed(stim_q[i]) > $signed(mx)) mx = stim_q[i];
            end else begin
                if (stim_q[i] < mn) mn = stim_q[i];
                if (stim_q[i] > mx) mx = stim_q[i];
            end
        end
        e.tag = tag;
        e.rng = mx - mn;
        e.mn  = mn;
        e.mx  = mx;
        e.cnt = 8'(stim_q.size());
        exp_q.push_back(e);

        signed_mode = sgn;
        for (int i = 0; i < stim_q.size(); i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk({tag, "_busy_run"},   32'(busy),   1);
                chk({tag, "_finish_run"}, 32'(finish), 0);
            end
            go = 1'b1;
            data_in = stim_q[i];
        end
        @(negedge clk);
        if (stim_q.size() == 1) begin
            chk({tag, "_busy_run"},   32'(busy),   1);
            chk({tag, "_finish_run"}, 32'(finish), 0);
        end
        go = 1'b0;

        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!finish && lat < 8);
        chk({tag, "_finish"},  32'(finish), 1);
        chk({tag, "_latency"}, lat, 1);
        e = exp_q.pop_front();
        chk({e.tag, "_range"}, 32'(range), 32'(e.rng));
        chk({e.tag, "_min"},   32'(min_o), 32'(e.mn));
        chk({e.tag, "_max"},   32'(max_o), 32'(e.mx));
        chk({e.tag, "_count"}, 32'(count), 32'(e.cnt));
        chk({e.tag, "_busy"},  32'(busy),  0);
        chk({e.tag, "_error"}, 32'(error), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset
        repeat (2) @(negedge clk);
        check_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("reset_rel");

        stim_q = '{8'd10, 8'd200, 8'd5, 8'd90};
        run_capture("basic", 1'b0);

        // back-to-back single-sample capture straight out of DONE
        stim_q = '{8'd42};
        run_capture("single", 1'b0);

        stim_q = '{8'h7F, 8'h80};
        run_capture("signed_on", 1'b1);
        run_capture("signed_off", 1'b0);

        stim_q = '{8'd33, 8'd33, 8'd33};
        run_capture("equal", 1'b0);

        // abort mid-RUN with go held high; results are nonzero beforehand
        stim_q = '{8'd1, 8'd250};
        run_capture("pre_abort", 1'b0);
        @(negedge clk); go = 1'b1; data_in = 8'd17;
        @(negedge clk); data_in = 8'd18;
        @(negedge clk); abort = 1'b1;
        @(negedge clk);
        check_zero("abort");
        abort = 1'b0; go = 1'b0;
        @(negedge clk);
        check_zero("abort_idle");

        // async reset mid-RUN
        stim_q = '{8'd50, 8'd60};
        run_capture("pre_rst", 1'b0);
        @(negedge clk); go = 1'b1; data_in = 8'd70;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async_rst");
        @(negedge clk); rst_n = 1'b1; go = 1'b0;
        @(negedge clk);
        check_zero("rst_release");
        stim_q = '{8'd8, 8'd4};
        run_capture("rearm_a", 1'b0);
        stim_q = '{8'd100, 8'd20, 8'd60};
        run_capture("rearm_b", 1'b0);

        // overflow on the MAX_SAMPLES=4 instance
        @(negedge clk); go4 = 1'b1; data_in = 8'd3;
        @(negedge clk); data_in = 8'd9;
        @(negedge clk); go4 = 1'b0;
        @(negedge clk);
        chk("ovf_pre_finish", 32'(finish4), 1);
        chk("ovf_pre_range",  32'(range4),  6);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 4) begin
                chk("ovf_4th_error", 32'(error4), 0);
                chk("ovf_4th_busy",  32'(busy4),  1);
            end
            go4 = 1'b1;
            data_in = 8'(20 + i);
        end
        @(negedge clk);
        chk("ovf_error",  32'(error4),  1);
        chk("ovf_busy",   32'(busy4),   0);
        chk("ovf_finish", 32'(finish4), 0);
        chk("ovf_range",  32'(range4),  0);
        chk("ovf_min",    32'(min4),    0);
        chk("ovf_max",    32'(max4),    0);
        chk("ovf_count",  32'(count4),  0);
        repeat (3) @(negedge clk);
        chk("ovf_stuck_error", 32'(error4), 1);
        chk("ovf_stuck_busy",  32'(busy4),  0);
        go4 = 1'b0;
        @(negedge clk); go4 = 1'b1; data_in = 8'd7;
        @(negedge clk);
        chk("ovf_restart_error", 32'(error4), 0);
        chk("ovf_restart_busy",  32'(busy4),  1);
        go4 = 1'b0;
        @(negedge clk);
        chk("ovf_clean_finish", 32'(finish4), 1);
        chk("ovf_clean_range",  32'(range4),  0);
        chk("ovf_clean_min",    32'(min4),    7);
        chk("ovf_clean_max",    32'(max4),    7);
        chk("ovf_clean_count",  32'(count4),  1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
